// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    GET_LEN,
    LOAD,
    DRAIN,
    CHECK,
    RUN,
    FAIL
  } boot_state_t;

endpackage

// File: rtl/mem_bus_mux.sv
// Memory bus select: loader pending-write register before RUN, CPU bus once running.
module mem_bus_mux #(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  run_sel,
  input  logic                  load_write,
  input  logic [addr_width-1:0] load_addr,
  input  logic [data_width-1:0] load_wdata,
  input  logic                  cpu_write,
  input  logic [addr_width-1:0] cpu_addr,
  input  logic [data_width-1:0] cpu_wdata,
  output logic                  mem_write,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_wdata
);

  assign mem_write = run_sel ? cpu_write : load_write;
  assign mem_addr  = run_sel ? cpu_addr  : load_addr;
  assign mem_wdata = run_sel ? cpu_wdata : load_wdata;

endmodule

// File: rtl/boot_loader.sv
// Boot loader: writes a length-prefixed host stream into memory from address 0, then releases the CPU.
// Optional feature macro BOOT_CHECKSUM_EN adds a trailing checksum word that must bring the payload sum to zero.
module boot_loader
  import boot_pkg::*;
#(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_data,
  output logic                  in_ready,
  input  logic                  cpu_write,
  input  logic [addr_width-1:0] cpu_addr,
  input  logic [data_width-1:0] cpu_wdata,
  output logic                  mem_write,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error
);

  localparam int CNT_W = addr_width + 1;
  localparam int CMP_W = (data_width > CNT_W) ? data_width : CNT_W;
  localparam logic [CNT_W-1:0] MAX_LEN = {1'b1, {addr_width{1'b0}}};

  boot_state_t state, next_state;

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      len;
  logic                  pend_write;
  logic [addr_width-1:0] pend_addr;
  logic [data_width-1:0] pend_wdata;
  logic                  run_sel;
  logic                  accept;
  logic                  oversize;
  logic                  last_word;
`ifdef BOOT_CHECKSUM_EN
  logic [data_width-1:0] sum;
`endif

  assign accept    = in_valid && in_ready;
  assign oversize  = CMP_W'(in_data) > CMP_W'(MAX_LEN);
  assign last_word = (cnt + CNT_W'(1)) == len;
  assign done      = run_sel;

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      GET_LEN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (oversize)
            next_state = FAIL;
          else if (in_data == '0)
`ifdef BOOT_CHECKSUM_EN
            next_state = CHECK;
`else
            next_state = RUN;
`endif
          else
            next_state = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_word)
`ifdef BOOT_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = DRAIN;
`endif
      end
      DRAIN: next_state = RUN;
`ifdef BOOT_CHECKSUM_EN
      CHECK: begin
        in_ready = 1'b1;
        if (in_valid)
          next_state = ((sum + in_data) == '0) ? RUN : FAIL;
      end
`endif
      RUN:     next_state = RUN;
      FAIL:    next_state = FAIL;
      default: next_state = FAIL;
    endcase
    // The host must never see a handshake while the loader is held in reset.
    if (rst)
      in_ready = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= GET_LEN;
      cnt        <= '0;
      len        <= '0;
      pend_write <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      run_sel    <= 1'b0;
      cpu_rst    <= 1'b1;
      error      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      state      <= next_state;
      pend_write <= 1'b0;
      if (accept && state == GET_LEN) begin
        len <= CNT_W'(in_data);
        cnt <= '0;
`ifdef BOOT_CHECKSUM_EN
        sum <= '0;
`endif
      end
      if (accept && state == LOAD) begin
        pend_write <= 1'b1;
        pend_addr  <= cnt[addr_width-1:0];
        pend_wdata <= in_data;
        cnt        <= cnt + CNT_W'(1);
`ifdef BOOT_CHECKSUM_EN
        sum        <= sum + in_data;
`endif
      end
      run_sel <= (next_state == RUN);
      cpu_rst <= (next_state != RUN);
      error   <= (next_state == FAIL);
    end
  end

  mem_bus_mux #(
    .addr_width(addr_width),
    .data_width(data_width)
  ) u_mux (
    .run_sel   (run_sel),
    .load_write(pend_write),
    .load_addr (pend_addr),
    .load_wdata(pend_wdata),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected memory writes are queued as words are sent, a monitor pops them.
module tb_boot_loader;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int MOD = 2 ** DW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          cpu_write = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          error;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int first_acc = 0;
  bit exp_run = 1'b0;
  wr_t exp_q[$];
  wr_t mon_e;
  logic [DW-1:0] payload[$];

  boot_loader #(
    .addr_width(AW),
    .data_width(DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .cpu_write(cpu_write),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Loader-phase writes must match the queued payload, in order, one pulse per word.
  always @(negedge clk) begin
    if (!rst && !done && mem_write) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        check_output("wr_data", 32'(mem_wdata), 32'(mon_e.data));
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    cpu_write = 1'b0;
    #1;
    check_output("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_output("rst_mem_write", 32'(mem_write), 32'd0);
    check_output("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_output("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_error", 32'(error), 32'd0);
    check_output("rst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int gap, output bit ok, output int acc);
    bit rdy;
    ok  = 1'b0;
    acc = -1;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = DW'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 40; i++) begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        #1 acc = cycle;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: word 0x%0h not accepted, expected acceptance within 40 cycles", w);
    end
  endtask

  // Sends length, payload and (when enabled) checksum; chk_mode 0=correct, 1=corrupt, 2=chk_val.
  task automatic apply_stimulus(input int gap_lo, input int gap_hi, input int chk_mode, input logic [DW-1:0] chk_val);
    int sum;
    int acc;
    bit ok;
    logic [DW-1:0] w;
    logic [DW-1:0] chk;
    sum = 0;
    exp_run = 1'b1;
    send_word(DW'(payload.size()), $urandom_range(gap_hi, gap_lo), ok, acc);
    first_acc = acc;
    if (!ok) begin in_valid = 1'b0; return; end
    for (int i = 0; i < payload.size(); i++) begin
      w = payload[i];
      exp_q.push_back({AW'(i), w});
      sum = (sum + int'(w)) % MOD;
      send_word(w, $urandom_range(gap_hi, gap_lo), ok, acc);
      if (!ok) begin in_valid = 1'b0; return; end
    end
`ifdef BOOT_CHECKSUM_EN
    if (chk_mode == 0)
      chk = DW'((MOD - sum) % MOD);
    else if (chk_mode == 1)
      chk = DW'((MOD - sum + 1 + int'($urandom_range(MOD - 2, 0))) % MOD);
    else
      chk = chk_val;
    exp_run = ((sum + int'(chk)) % MOD) == 0;
    send_word(chk, $urandom_range(gap_hi, gap_lo), ok, acc);
`else
    chk = chk_val;
    if (chk_mode > 2) $display("[TB] note: checksum 0x%0h unused", chk);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = DW'($urandom);
  endtask

  task automatic check_final(input bit check_latency);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit wr;
    int waited;
    waited = 0;
    while (!(done || error) && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    check_output("done", 32'(done), 32'(exp_run));
    check_output("error", 32'(error), 32'(!exp_run));
    check_output("cpu_rst", 32'(cpu_rst), 32'(!exp_run));
    check_output("writes_left", 32'(exp_q.size()), 32'd0);
    if (check_latency && exp_run)
      check_output("run_edge", 32'(cycle - first_acc + 1), 32'(payload.size() + 2));
    if (exp_run) begin
      @(negedge clk);
      cpu_write = 1'b1; cpu_addr = 8'h80; cpu_wdata = 8'hAA; in_valid = 1'b1;
      #1;
      check_output("pass_write", 32'(mem_write), 32'd1);
      check_output("pass_addr", 32'(mem_addr), 32'h80);
      check_output("pass_wdata", 32'(mem_wdata), 32'hAA);
      check_output("run_in_ready", 32'(in_ready), 32'd0);
      wr = 1'($urandom); a = AW'($urandom); d = DW'($urandom);
      cpu_write = wr; cpu_addr = a; cpu_wdata = d;
      #1;
      check_output("pass_rand", {15'd0, mem_write, mem_addr, mem_wdata}, {15'd0, wr, a, d});
      @(negedge clk);
      check_output("run_sticky", 32'({done, cpu_rst}), 32'b10);
    end else begin
      @(negedge clk);
      cpu_write = 1'b1; cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom); in_valid = 1'b1;
      #1;
      check_output("fail_mem_write", 32'(mem_write), 32'd0);
      check_output("fail_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check_output("fail_sticky", 32'({error, cpu_rst, done}), 32'b110);
    end
    cpu_write = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int acc;
    int n;
    apply_reset();

`ifdef BOOT_CHECKSUM_EN
    payload = '{8'h10, 8'h20};
    apply_stimulus(0, 0, 2, 8'hD0);
    check_final(1'b1);
    apply_reset();
    payload = '{8'h10, 8'h20};
    apply_stimulus(0, 0, 2, 8'hD1);
    check_final(1'b0);
`else
    payload = '{8'h05, 8'h07, 8'h09};
    apply_stimulus(0, 0, 0, 8'h00);
    check_final(1'b1);
`endif

    apply_reset();
    payload.delete();
    apply_stimulus(0, 0, 0, 8'h00);
    check_final(1'b0);

    apply_reset();
    payload.delete();
    for (int i = 0; i < 4; i++) payload.push_back(DW'($urandom));
    apply_stimulus(1, 1, 0, 8'h00);
    check_final(1'b0);

    // Abort a load after two of four words, then reload a one-word program.
    apply_reset();
    payload.delete();
    for (int i = 0; i < 4; i++) payload.push_back(DW'($urandom));
    send_word(8'd4, 0, ok, acc);
    exp_q.push_back({AW'(0), payload[0]});
    send_word(payload[0], 0, ok, acc);
    send_word(payload[1], 0, ok, acc);
    #1 rst = 1'b1;
    #1;
    check_output("abort_mem_write", 32'(mem_write), 32'd0);
    check_output("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    check_output("abort_in_ready", 32'(in_ready), 32'd0);
    check_output("abort_writes_left", 32'(exp_q.size()), 32'd0);
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    payload = '{8'h3C};
    apply_stimulus(0, 0, 0, 8'h00);
    check_final(1'b1);

    for (int t = 0; t < 6; t++) begin
      apply_reset();
      payload.delete();
      n = $urandom_range(10, 1);
      for (int i = 0; i < n; i++) payload.push_back(DW'($urandom));
      apply_stimulus(0, 2, int'($urandom_range(1, 0)), 8'h00);
      check_final(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
